req_initiator: RTL
==================

Name: req_initiator

Overview:
- Four-channel request initiator. It drives req_0..req_3 into the shared ctrl arbiter and consumes its ack_0..ack_3, using a four-phase return-to-zero handshake per channel.
- Local clients issue one-cycle start pulses; the block runs the handshake and reports completion, timeouts and protocol faults.
- It sits between client logic and ctrl, one instance per request group.

Parameters:
- TIMEOUT, 200, cycles req_n may stay high without ack_n before the request is abandoned (legal range 2..2**TO_W-1).
- TO_W, 8, width of each per-channel timeout counter.
- CNT_W, 16, width of the grant_cnt completion counter.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- start  input  4  per-channel one-cycle request pulse; bit n maps to channel n.
- ack_0..ack_3  input  1 each  grant acknowledge from ctrl; synchronous to clk.
- clear_err  input  1  clears timeout_err and proto_err.
- req_0..req_3  output  1 each  registered request to ctrl.
- busy  output  4  channel n is not IDLE.
- done  output  4  one-cycle pulse per completed handshake.
- timeout_err  output  4  sticky per-channel timeout flag.
- proto_err  output  1  sticky protocol-violation flag (see Optional Feature).
- grant_cnt  output  CNT_W  total completed handshakes, all channels.

Behaviour:
- Reset (synchronous, active-high):
  - At the next edge: all req_n=0, busy=0, done=0, timeout_err=0, proto_err=0, grant_cnt=0.
  - All FSMs go to IDLE; pending bits and counters are cleared.
  - Applies mid-handshake as well; the block does not wait for ack to fall.
- Per-channel FSM with states IDLE, REQ, REL. All outputs are registered.
- IDLE:
  - start[n]=1 at edge N -> REQ; req_n=1 from N+1.
  - ack_n is ignored in IDLE.
- REQ: req_n=1. The timeout counter increments each cycle ack_n=0.
  - ack_n=1 sampled at edge M -> REL; req_n=0 from M+1.
  - If the counter reaches TIMEOUT with ack_n still 0: -> REL, req_n=0, timeout_err[n]=1, pending[n] cleared, no done.
  - If ack_n=1 and the timeout occur in the same cycle, ack wins (normal completion).
- REL: req_n=0, waiting for ack_n=0.
  - ack_n=0 sampled at edge K -> done[n]=1 for one cycle at K+1 (completed handshakes only), and grant_cnt increments.
  - Next state: REQ if pending[n]=1 (req_n high again at K+1 and pending[n] cleared), otherwise IDLE.
  - req_n is therefore low for at least one full cycle between requests.
- Pending:
  - start[n] while busy[n]=1 sets pending[n]; depth 1, extra starts are dropped.
  - start[n] in IDLE is taken directly and never sets pending.
- grant_cnt:
  - Adds the popcount of done completions in each cycle (0..4).
  - Wraps modulo 2**CNT_W.
- Channels are fully independent; simultaneous starts on all four channels raise all four reqs in the same cycle.
- clear_err:
  - Clears timeout_err and proto_err at the next edge.
  - If a set event occurs in the same cycle, set wins.
- busy[n] = (state != IDLE), registered alongside the state.

Optional Feature:
- Macro: REQ_INITIATOR_PROTO_CHECK_EN.
- Defined: proto_err is set (sticky) when either
  - more than one ack_n is high in the same cycle (non-exclusive grant from ctrl), or
  - ack_n is high while channel n is IDLE (unsolicited ack).
- Not defined: proto_err is tied to 0 and the checking logic is not synthesised. All other behaviour is identical.

Test Plan:
- Basic handshake on channel 0:
  - Stimulus: reset 2 cycles; start=4'b0001 at cycle 5; ack_0 rises at cycle 8 and falls at cycle 11.
  - Response: req_0 high cycles 6..8, low from 9; done[0] pulses at 12; grant_cnt=1; busy[0] low from 12.
- Timeout on channel 2:
  - Stimulus: TIMEOUT=4; start[2] pulsed; ack_2 held 0.
  - Response: req_2 high for exactly 4 cycles then low; timeout_err[2]=1; no done[2]; grant_cnt unchanged.
  - Follow-up: clear_err=1 for one cycle -> timeout_err=0.
- Pending re-issue on channel 1:
  - Stimulus: start[1] during REQ, then two more starts during REL.
  - Response: exactly 2 handshakes total; req_1 low for at least 1 cycle between them; grant_cnt=2.
- Simultaneous completions:
  - Stimulus: all four channels started; acks rise and fall together.
  - Response: done=4'b1111 in one cycle; grant_cnt += 4.
- Reset mid-operation:
  - Stimulus: reset asserted while req_3=1 and ack_3=1.
  - Response: req_3=0 and busy=0 next cycle; grant_cnt=0; no done pulse.
- Protocol check (with REQ_INITIATOR_PROTO_CHECK_EN):
  - Stimulus: ack_0 and ack_1 high together; ack_2 high while channel 2 is IDLE.
  - Response: proto_err=1 and stays set until clear_err.
  - Without the macro: proto_err stays 0 for the same stimulus.

Source files
------------

// File: rtl/req_initiator.sv
// req_initiator: four-channel four-phase req/ack initiator; define REQ_INITIATOR_PROTO_CHECK_EN to enable the ack protocol checker
module req_initiator #(
  parameter int TIMEOUT = 200,
  parameter int TO_W = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       start,
  input  logic             ack_0,
  input  logic             ack_1,
  input  logic             ack_2,
  input  logic             ack_3,
  input  logic             clear_err,
  output logic             req_0,
  output logic             req_1,
  output logic             req_2,
  output logic             req_3,
  output logic [3:0]       busy,
  output logic [3:0]       done,
  output logic [3:0]       timeout_err,
  output logic             proto_err,
  output logic [CNT_W-1:0] grant_cnt
);
  typedef enum logic [1:0] {IDLE, REQ, REL} state_t;
  state_t           r_st     [4];
  logic [TO_W-1:0]  r_to_cnt [4];
  logic [3:0]       r_req, r_busy, r_done, r_to_err, r_pend, r_to_rel;
  logic [CNT_W-1:0] r_grant;
  logic [3:0]       w_ack, w_done, w_to;
  logic [2:0]       w_pop;
  // release/timeout decode per channel; a release after a timeout is not a completion
  always_comb begin
    w_ack  = {ack_3, ack_2, ack_1, ack_0};
    w_done = '0;
    w_to   = '0;
    for (int n = 0; n < 4; n++) begin
      w_done[n] = r_st[n] == REL && !w_ack[n] && !r_to_rel[n];
      w_to[n]   = r_st[n] == REQ && !w_ack[n] && r_to_cnt[n] == TO_W'(TIMEOUT - 1);
    end
    w_pop = 3'(w_done[0]) + 3'(w_done[1]) + 3'(w_done[2]) + 3'(w_done[3]);
  end
  // per-channel handshake FSMs, pending bits, sticky timeout flags and completion counter
  always_ff @(posedge clk) begin
    if (reset) begin
      r_grant  <= '0;
      r_done   <= '0;
      r_to_err <= '0;
      r_req    <= '0;
      r_busy   <= '0;
      r_pend   <= '0;
      r_to_rel <= '0;
      for (int n = 0; n < 4; n++) begin
        r_st[n]     <= IDLE;
        r_to_cnt[n] <= '0;
      end
    end else begin
      r_done   <= w_done;
      r_grant  <= r_grant + CNT_W'(w_pop);
      r_to_err <= (r_to_err & ~{4{clear_err}}) | w_to;
      for (int n = 0; n < 4; n++) begin
        case (r_st[n])
          IDLE: if (start[n]) begin
            r_st[n]     <= REQ;
            r_req[n]    <= 1'b1;
            r_busy[n]   <= 1'b1;
            r_to_cnt[n] <= '0;
          end
          REQ: begin
            r_pend[n]   <= (r_pend[n] | start[n]) & !w_to[n];
            r_to_cnt[n] <= r_to_cnt[n] + TO_W'(1);
            if (w_ack[n] || w_to[n]) begin
              r_st[n]     <= REL;
              r_req[n]    <= 1'b0;
              r_to_rel[n] <= w_to[n];
            end
          end
          REL: begin
            if (w_ack[n]) begin
              r_pend[n] <= r_pend[n] | start[n];
            end else if (r_pend[n] | start[n]) begin
              r_st[n]     <= REQ;
              r_req[n]    <= 1'b1;
              r_pend[n]   <= 1'b0;
              r_to_cnt[n] <= '0;
              r_to_rel[n] <= 1'b0;
            end else begin
              r_st[n]     <= IDLE;
              r_busy[n]   <= 1'b0;
              r_to_rel[n] <= 1'b0;
            end
          end
          default: begin
            r_st[n]   <= IDLE;
            r_req[n]  <= 1'b0;
            r_busy[n] <= 1'b0;
          end
        endcase
      end
    end
  end
`ifdef REQ_INITIATOR_PROTO_CHECK_EN
  logic r_proto;
  logic w_proto_set;
  assign w_proto_set = |(w_ack & (w_ack - 4'd1)) || |(w_ack & ~r_busy);
  // sticky flag for non-exclusive or unsolicited acks; a new violation beats clear_err
  always_ff @(posedge clk) begin
    r_proto <= reset ? 1'b0 : (r_proto & !clear_err) | w_proto_set;
  end
  assign proto_err = r_proto;
`else
  assign proto_err = 1'b0;
`endif
  assign req_0       = r_req[0];
  assign req_1       = r_req[1];
  assign req_2       = r_req[2];
  assign req_3       = r_req[3];
  assign busy        = r_busy;
  assign done        = r_done;
  assign timeout_err = r_to_err;
  assign grant_cnt   = r_grant;
endmodule
